// File: rtl/round_controller.sv
// Baccarat round sequencer: steps the card/wager datapath through one hand,
// applies the drawing rules and reports the hand result.
module round_controller #(
  parameter int unsigned NATURAL = 8,
  parameter int unsigned PSTAND  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       place_bet,
  input  logic       balance_zero,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       betting,
  output logic       load_wager,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic [1:0] result,
  output logic [1:0] winner,
  output logic       game_over,
  output logic [3:0] state_out
);

  localparam logic [3:0] NATURAL_L = 4'(NATURAL);
  localparam logic [3:0] PSTAND_L  = 4'(PSTAND);

  typedef enum logic [3:0] {
    S_BET   = 4'd0,
    S_P1    = 4'd1,
    S_D1    = 4'd2,
    S_P2    = 4'd3,
    S_D2    = 4'd4,
    S_CHK   = 4'd5,
    S_P3    = 4'd6,
    S_CHKD  = 4'd7,
    S_D3    = 4'd8,
    S_SCORE = 4'd9,
    S_DONE  = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] winner_q, winner_d;

  logic [3:0] t_val_c;
  logic       natural_c;
  logic       dealer_draw_c;
  logic [1:0] cmp_c;

  // Drawing-rule and hand-comparison terms from the live scores
  always_comb begin
    t_val_c   = (pcard3 >= 4'd10) ? 4'd0 : pcard3;
    natural_c = (pscore >= NATURAL_L) || (dscore >= NATURAL_L);
    dealer_draw_c = (dscore <= 4'd2)
                 || ((dscore == 4'd3) && (t_val_c != 4'd8))
                 || ((dscore == 4'd4) && (t_val_c >= 4'd2) && (t_val_c <= 4'd7))
                 || ((dscore == 4'd5) && (t_val_c >= 4'd4) && (t_val_c <= 4'd7))
                 || ((dscore == 4'd6) && (t_val_c >= 4'd6) && (t_val_c <= 4'd7));
    if (pscore > dscore)      cmp_c = 2'b01;
    else if (dscore > pscore) cmp_c = 2'b10;
    else                      cmp_c = 2'b11;
  end

  // Next-state and winner latch; unused encodings fall back to BET unconditionally
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    case (state_q)
      S_BET:   if (step && place_bet && !balance_zero) state_d = S_P1;
      S_P1:    if (step) state_d = S_D1;
      S_D1:    if (step) state_d = S_P2;
      S_P2:    if (step) state_d = S_D2;
      S_D2:    if (step) state_d = S_CHK;
      S_CHK: begin
        if (step) begin
          if (natural_c)              state_d = S_SCORE;
          else if (pscore < PSTAND_L) state_d = S_P3;
          else if (dscore <= 4'd5)    state_d = S_D3;
          else                        state_d = S_SCORE;
        end
      end
      S_P3:    if (step) state_d = S_CHKD;
      S_CHKD:  if (step) state_d = dealer_draw_c ? S_D3 : S_SCORE;
      S_D3:    if (step) state_d = S_SCORE;
      S_SCORE: begin
        if (step) begin
          state_d  = S_DONE;
          winner_d = cmp_c;
        end
      end
      S_DONE:  if (step) state_d = S_BET;
      default: state_d = S_BET;
    endcase
  end

  // Moore strobes gated by step; held quiet while reset is asserted
  always_comb begin
    betting     = (state_q == S_BET);
    load_wager  = 1'b0;
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    result      = 2'b00;
    if (step && !reset) begin
      load_wager  = (state_q == S_BET) && place_bet && !balance_zero;
      load_pcard1 = (state_q == S_P1);
      load_pcard2 = (state_q == S_P2);
      load_pcard3 = (state_q == S_P3);
      load_dcard1 = (state_q == S_D1);
      load_dcard2 = (state_q == S_D2);
      load_dcard3 = (state_q == S_D3);
      result      = (state_q == S_SCORE) ? cmp_c : 2'b00;
    end
    game_over = (state_q == S_BET) && balance_zero;
    winner    = winner_q;
    state_out = state_q;
  end

  // State and winner registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_BET;
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller: hands are planned as a list of
// visited states from the baccarat rules and replayed with random step gaps.
module tb_round_controller;

  logic       clk = 1'b0;
  logic       reset, step, place_bet, balance_zero;
  logic [3:0] pscore, dscore, pcard3;
  logic       betting, load_wager;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic [1:0] result, winner;
  logic       game_over;
  logic [3:0] state_out;

  round_controller #(.NATURAL(8), .PSTAND(6)) dut (
    .clk(clk), .reset(reset), .step(step), .place_bet(place_bet),
    .balance_zero(balance_zero), .pscore(pscore), .dscore(dscore),
    .pcard3(pcard3), .betting(betting), .load_wager(load_wager),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .result(result), .winner(winner), .game_over(game_over), .state_out(state_out)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: current state number, planned path, last winner
  int         s = 0;
  int         path[$];
  logic [1:0] winner_m = 2'b00;
  int         hp2, hd2, hpf, hdf, ht3;
  // Highest dealer score that still draws, indexed by player third-card value
  int         dealer_limit[10] = '{3, 3, 4, 4, 5, 5, 6, 6, 2, 3};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] outcome(input int p, input int d);
    if (p > d) return 2'b01;
    if (d > p) return 2'b10;
    return 2'b11;
  endfunction

  // Sequence of states a hand visits after leaving BET, ending back in BET
  task automatic plan_hand(input int p, input int d, input int t);
    int tv;
    tv = (t >= 10) ? 0 : t;
    path.delete();
    path = '{1, 2, 3, 4, 5};
    if (p >= 8 || d >= 8) begin
    end else if (p < 6) begin
      path.push_back(6);
      path.push_back(7);
      if (d <= dealer_limit[tv]) path.push_back(8);
    end else if (d <= 5) begin
      path.push_back(8);
    end
    path.push_back(9);
    path.push_back(10);
    path.push_back(0);
  endtask

  // One clock: drive at negedge, check outputs mid-low-phase, advance model at posedge
  task automatic cyc(input logic st);
    logic [1:0] exp_res;
    logic [5:0] exp_ld;
    step = st;
    if (s == 9) begin
      pscore = 4'(hpf); dscore = 4'(hdf);
    end else if (s >= 5) begin
      pscore = 4'(hp2); dscore = 4'(hd2);
    end else begin
      pscore = 4'($urandom_range(9)); dscore = 4'($urandom_range(9));
    end
    pcard3 = 4'(ht3);
    #2;
    exp_res = (s == 9 && st) ? outcome(hpf, hdf) : 2'b00;
    exp_ld = 6'b000000;
    if (st) begin
      case (s)
        1: exp_ld = 6'b100000;
        3: exp_ld = 6'b010000;
        6: exp_ld = 6'b001000;
        2: exp_ld = 6'b000100;
        4: exp_ld = 6'b000010;
        8: exp_ld = 6'b000001;
        default: exp_ld = 6'b000000;
      endcase
    end
    chk("state_out", 8'(state_out), 8'(s));
    chk("betting", 8'(betting), 8'(s == 0));
    chk("load_wager", 8'(load_wager), 8'(s == 0 && st && place_bet && !balance_zero));
    chk("card_strobes", 8'({load_pcard1, load_pcard2, load_pcard3,
                            load_dcard1, load_dcard2, load_dcard3}), 8'(exp_ld));
    chk("result", 8'(result), 8'(exp_res));
    chk("winner", 8'(winner), 8'(winner_m));
    chk("game_over", 8'(game_over), 8'(s == 0 && balance_zero));
    @(posedge clk);
    if (st) begin
      if (s == 0) begin
        if (place_bet && !balance_zero && path.size() > 0) s = path.pop_front();
      end else begin
        if (s == 9) winner_m = outcome(hpf, hdf);
        if (path.size() > 0) s = path.pop_front();
        else s = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_hand(input int p2, input int d2, input int t3, input int pf, input int df,
                          input int prob, input bit hold, input bit rand_pb);
    int  guard;
    bit  left;
    bit  held;
    plan_hand(p2, d2, t3);
    hp2 = p2; hd2 = d2; ht3 = t3; hpf = pf; hdf = df;
    balance_zero = 1'b0;
    guard = 0; left = 1'b0; held = 1'b0;
    do begin
      place_bet = rand_pb ? 1'($urandom_range(1)) : 1'b1;
      if (hold && !held && s == 10) begin
        repeat (10) cyc(1'b0);
        held = 1'b1;
      end
      cyc(1'($urandom_range(99) < prob));
      if (s != 0) left = 1'b1;
      guard++;
    end while (!(left && s == 0) && guard < 400);
    chk("hand_completes", 8'(guard < 400), 8'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; step = 1'b0; place_bet = 1'b0; balance_zero = 1'b0;
    pscore = 4'd0; dscore = 4'd0; pcard3 = 4'd0;
    hp2 = 0; hd2 = 0; hpf = 0; hdf = 0; ht3 = 0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_state", 8'(state_out), 8'd0);
    chk("rst_betting", 8'(betting), 8'd1);
    chk("rst_winner", 8'(winner), 8'd0);
    reset = 1'b0;
    @(negedge clk);

    // Broke player: place_bet ignored, game_over shown
    place_bet = 1'b1; balance_zero = 1'b1;
    repeat (5) cyc(1'b1);

    // Natural: player 9 vs dealer 3
    run_hand(9, 3, 0, 9, 3, 100, 1'b0, 1'b0);
    // Player draws, dealer stands on 6 against an 8
    run_hand(4, 6, 8, 2, 6, 100, 1'b0, 1'b0);
    // Dealer 3 stands against an 8, draws against a face card
    run_hand(2, 3, 8, 0, 3, 100, 1'b0, 1'b0);
    run_hand(2, 3, 12, 2, 5, 100, 1'b0, 1'b0);
    // Tie with a long idle in DONE
    run_hand(7, 7, 0, 7, 7, 100, 1'b1, 1'b0);

    // Asynchronous reset mid-hand in D1 with step held high
    plan_hand(5, 5, 0);
    place_bet = 1'b1;
    cyc(1'b1);
    cyc(1'b1);
    step = 1'b1; place_bet = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rst_state", 8'(state_out), 8'd0);
    chk("mid_rst_betting", 8'(betting), 8'd1);
    chk("mid_rst_strobes", 8'({load_wager, load_pcard1, load_pcard2, load_pcard3,
                               load_dcard1, load_dcard2, load_dcard3}), 8'd0);
    chk("mid_rst_result", 8'(result), 8'd0);
    chk("mid_rst_winner", 8'(winner), 8'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold", 8'(state_out), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    s = 0; winner_m = 2'b00; path.delete();

    // Random hands with random step gaps and place_bet dither
    for (int h = 0; h < 40; h++) begin
      run_hand(int'($urandom_range(9)), int'($urandom_range(9)), int'($urandom_range(13)),
               int'($urandom_range(9)), int'($urandom_range(9)), 60, 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
